mux_sel_arbiter: RTL and testbench

Round-robin arbiter and select sequencer for the 8-input mux tree: two 4:1 muxes (inputs a–d on s1:s0, inputs e–h on s3:s2) feeding a final 2:1 mux on x. Eight requesters share the single mux output. The block grants one requester at a time for a bounded dwell and drives the five select lines so the granted input reaches `out`. It inserts a one-cycle break-before-make gap between grants so downstream logic never samples a half-switched path.

---
 rtl/mux_sel_arbiter.sv | 120 ++++++++++++
 tb/tb_mux_sel_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter and select sequencer for the 8-input (2x 4:1 + 2:1) mux tree.
// Grants one requester for a bounded dwell, with a one-cycle break-before-make gap between grants.
module mux_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       x
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [2:0]    cur_q, cur_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    win_s;

  // First set request scanning p, p+1, ... p+7 modulo 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    idx     = p;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    win_s         = rr_pick(req, ptr_q);
    case (state_q)
      IDLE, GAP: begin
        if (req != 8'h00) begin
          cur_d   = win_s;
          cnt_d   = HOLD_INIT;
          sel_d   = win_s;
          grant_d = 8'h01 << win_s;
          state_d = GRANT;
        end else begin
          grant_d = 8'h00;
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release on dropped request or exhausted dwell; the released index drops to lowest priority.
        if (!req[cur_q] || (cnt_q == '0)) begin
          grant_d = 8'h00;
          ptr_d   = cur_q + 3'd1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        grant_d = 8'h00;
        state_d = IDLE;
      end
    endcase
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_q         <= 3'd0;
      ptr_q         <= 3'd0;
      cnt_q         <= '0;
      grant_q       <= 8'h00;
      grant_valid_q <= 1'b0;
      sel_q         <= 3'd0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      sel_q         <= sel_d;
    end
  end

  // Both 4:1 muxes get the same low index bits; only x picks the half.
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign s0          = sel_q[0];
  assign s2          = sel_q[0];
  assign s1          = sel_q[1];
  assign s3          = sel_q[1];
  assign x           = sel_q[2];

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: behavioural round-robin model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mux_sel_arbiter;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic       grant_valid, s0, s1, s2, s3, x;

  int vectors = 0;
  int miscompares = 0;

  mux_sel_arbiter #(.HOLD_CYCLES(HOLD), .CW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_valid(grant_valid),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .x(x)
  );

  always #5 clk = ~clk;

  // Model: who holds the mux, for how many cycles so far, where the next scan starts.
  bit m_busy;
  int m_idx, m_age, m_start, m_sel;

  function automatic int pick(input logic [7:0] r, input int start);
    for (int i = 0; i < 8; i++)
      if (r[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_idx = 0; m_age = 0; m_start = 0; m_sel = 0;
    end else if (m_busy) begin
      m_age++;
      if (!req[m_idx] || m_age >= HOLD) begin
        m_busy  = 0;
        m_start = (m_idx + 1) % 8;
      end
    end else if (req != 8'h00) begin
      m_idx  = pick(req, m_start);
      m_sel  = m_idx;
      m_busy = 1;
      m_age  = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("grant", {24'd0, grant}, m_busy ? (32'd1 << m_idx) : 32'd0);
      check("grant_valid", {31'd0, grant_valid}, {31'd0, m_busy});
      check("selects", {27'd0, x, s3, s2, s1, s0},
            {27'd0, m_sel[2] != 0, m_sel[1] != 0, m_sel[0] != 0, m_sel[1] != 0, m_sel[0] != 0});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step_check(input string name, input logic [7:0] exp_g);
    @(posedge clk);
    #1;
    check(name, {24'd0, grant}, {24'd0, exp_g});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_grant", {24'd0, grant}, 32'd0);
    check("reset_sel", {27'd0, x, s3, s2, s1, s0}, 32'd0);
    rst = 1'b0;

    // Single requester 6: 4-cycle dwell, one gap, regrant.
    @(negedge clk); req = 8'h40;
    for (int k = 0; k < HOLD; k++) step_check("single_dwell", 8'h40);
    check("single_sel", {27'd0, x, s3, s2, s1, s0}, {27'd0, 5'b11010});
    step_check("single_gap", 8'h00);
    step_check("single_regrant", 8'h40);

    // Round-robin over all inputs.
    do_reset(); req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step_check("rr_order", 8'h01 << (i % 8));
      check("rr_x", {31'd0, x}, (i % 8) >= 4 ? 32'd1 : 32'd0);
      check("rr_s10", {30'd0, s1, s0}, 32'(i % 4));
      repeat (HOLD) @(posedge clk);
    end

    // Early release of 2 with 3 pending.
    do_reset(); req = 8'h04;
    step_check("early_grant", 8'h04);
    @(negedge clk); req = 8'h08;
    step_check("early_gap", 8'h00);
    step_check("early_next", 8'h08);

    // Priority rotation: 6 then 0 then 6.
    do_reset(); req = 8'h40;
    step_check("rot_first", 8'h40);
    @(negedge clk); req = 8'h41;
    repeat (3) @(posedge clk);
    step_check("rot_gap1", 8'h00);
    step_check("rot_zero", 8'h01);
    repeat (3) @(posedge clk);
    step_check("rot_gap2", 8'h00);
    step_check("rot_six", 8'h40);

    // Wrap to idle with selects holding index 7.
    do_reset(); req = 8'h80;
    step_check("wrap_grant", 8'h80);
    @(negedge clk); req = 8'h00;
    step_check("wrap_gap", 8'h00);
    step_check("wrap_idle", 8'h00);
    check("wrap_sel", {27'd0, x, s3, s2, s1, s0}, {27'd0, 5'b11111});
    @(negedge clk); req = 8'h01;
    step_check("wrap_ptr0", 8'h01);

    // Asynchronous reset mid-grant of input 5.
    do_reset(); req = 8'h20;
    step_check("mid_grant", 8'h20);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_grant", {24'd0, grant}, 32'd0);
    check("mid_rst_valid", {31'd0, grant_valid}, 32'd0);
    check("mid_rst_sel", {27'd0, x, s3, s2, s1, s0}, 32'd0);
    @(negedge clk); rst = 1'b0; req = 8'h01;
    step_check("post_rst", 8'h01);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0: req = 8'h00;
        1, 2: req = 8'($urandom);
        3: req = req ^ (8'h01 << $urandom_range(0, 7));
        default: req = req;
      endcase
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
